// File: rtl/fifo_drain_arbiter.sv
// Read-side controller for a bank of FIFOs: programs their thresholds, pops them
// round-robin and forwards each word to a single downstream FIFO write port.
module fifo_drain_arbiter #(
  parameter int DATA_SIZE = 4,
  parameter int NUM_FIFOS = 4,
  parameter int SEL_W     = 2
) (
  input  logic                           clk,
  input  logic                           reset_L,
  input  logic                           init,
  input  logic [DATA_SIZE-1:0]           umb_af_in,
  input  logic [DATA_SIZE-1:0]           umb_ae_in,
  input  logic [NUM_FIFOS-1:0]           fifo_empty,
  input  logic [NUM_FIFOS-1:0]           fifo_error,
  input  logic [NUM_FIFOS*DATA_SIZE-1:0] fifo_data,
  input  logic                           down_almost_full,
  input  logic                           down_full,
  output logic [DATA_SIZE-1:0]           umb_almost_full,
  output logic [DATA_SIZE-1:0]           umb_almost_empty,
  output logic [NUM_FIFOS-1:0]           pop,
  output logic                           push_out,
  output logic [DATA_SIZE-1:0]           data_out,
  output logic [4:0]                     state,
  output logic                           idle_out,
  output logic                           error_out
);

  typedef enum logic [4:0] {
    S_RESET  = 5'b00001,
    S_INIT   = 5'b00010,
    S_IDLE   = 5'b00100,
    S_ACTIVE = 5'b01000,
    S_ERROR  = 5'b10000
  } state_t;

  state_t           cur, nxt;
  logic [SEL_W-1:0] gnt, sel, cand, idx1;
  logic             found, v1, busy, err_hit;

  assign state   = cur;
  assign busy    = v1 | push_out;
  assign err_hit = (|fifo_error) | (down_full & push_out);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of process ordering.
  always_ff @(posedge clk) begin
    if (!reset_L) cur <= S_RESET;
    else          cur <= nxt;
  end

  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    nxt = cur;
    unique case (cur)
      S_RESET:  nxt = S_INIT;
      S_INIT:   if (!init) nxt = S_IDLE;
      S_IDLE:   if (init) nxt = S_INIT;
                else if (!(&fifo_empty)) nxt = S_ACTIVE;
      S_ACTIVE: if (init) nxt = S_INIT;
                else if ((&fifo_empty) && !busy) nxt = S_IDLE;
      S_ERROR:  nxt = S_ERROR;
      default:  nxt = S_RESET;
    endcase
    if (cur != S_RESET && err_hit) nxt = S_ERROR;
  end

  // Round-robin search: first non-empty FIFO after the last granted one.
  always_comb begin
    sel   = gnt;
    cand  = gnt;
    found = 1'b0;
    for (int i = 1; i <= NUM_FIFOS; i++) begin
      cand = gnt + SEL_W'(i);
      if (!found && !fifo_empty[cand]) begin
        sel   = cand;
        found = 1'b1;
      end
    end
  end

  // The two-stage pipeline bounds in-flight words to 2, so stalling new pops on
  // almost_full alone keeps the downstream slack sufficient.
  always_comb begin
    pop = '0;
    if (cur == S_ACTIVE && found && !down_almost_full) pop[sel] = 1'b1;
    idle_out = (cur == S_IDLE) && (&fifo_empty) && !busy;
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      umb_almost_full  <= '0;
      umb_almost_empty <= '0;
      gnt              <= SEL_W'(NUM_FIFOS - 1);
      v1               <= 1'b0;
      idx1             <= '0;
      push_out         <= 1'b0;
      data_out         <= '0;
      error_out        <= 1'b0;
    end else begin
      if (cur == S_INIT) begin
        umb_almost_full  <= umb_af_in;
        umb_almost_empty <= umb_ae_in;
      end
      if (|pop) gnt <= sel;
      // Entering or staying in ERROR flushes the pipeline without a push.
      if (nxt == S_ERROR) begin
        v1        <= 1'b0;
        push_out  <= 1'b0;
        error_out <= 1'b1;
      end else begin
        v1       <= |pop;
        idx1     <= sel;
        push_out <= v1;
        if (v1) data_out <= fifo_data[idx1*DATA_SIZE +: DATA_SIZE];
      end
    end
  end

endmodule

// File: tb/tb_fifo_drain_arbiter.sv
// Bench for fifo_drain_arbiter: behavioural upstream FIFOs, a push scoreboard
// with exact pop-to-push latency, and a table of control-phase vectors.
module tb_fifo_drain_arbiter;
  localparam int DS = 4;
  localparam int NF = 4;
  localparam int SW = 2;
  localparam logic [4:0] ST_RESET  = 5'd1;
  localparam logic [4:0] ST_INIT   = 5'd2;
  localparam logic [4:0] ST_IDLE   = 5'd4;
  localparam logic [4:0] ST_ERROR  = 5'd16;

  logic             clk = 1'b0;
  logic             reset_L = 1'b0;
  logic             init = 1'b1;
  logic [DS-1:0]    umb_af_in = '0;
  logic [DS-1:0]    umb_ae_in = '0;
  logic [NF-1:0]    fifo_empty;
  logic [NF-1:0]    fifo_error;
  logic [NF*DS-1:0] fifo_data;
  logic             down_almost_full = 1'b0;
  logic             down_full = 1'b0;
  logic [DS-1:0]    umb_almost_full, umb_almost_empty, data_out;
  logic [NF-1:0]    pop;
  logic             push_out, idle_out, error_out;
  logic [4:0]       state;

  fifo_drain_arbiter #(.DATA_SIZE(DS), .NUM_FIFOS(NF), .SEL_W(SW)) dut (
    .clk(clk), .reset_L(reset_L), .init(init),
    .umb_af_in(umb_af_in), .umb_ae_in(umb_ae_in),
    .fifo_empty(fifo_empty), .fifo_error(fifo_error), .fifo_data(fifo_data),
    .down_almost_full(down_almost_full), .down_full(down_full),
    .umb_almost_full(umb_almost_full), .umb_almost_empty(umb_almost_empty),
    .pop(pop), .push_out(push_out), .data_out(data_out),
    .state(state), .idle_out(idle_out), .error_out(error_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DS-1:0] data;
    int            due;
  } exp_t;

  typedef struct {
    logic          rst_v;
    logic          init_v;
    logic [DS-1:0] af_v;
    logic [DS-1:0] ae_v;
    logic [4:0]    exp_state;
    logic [DS-1:0] exp_af;
    logic [DS-1:0] exp_ae;
    logic          exp_idle;
  } vec_t;

  exp_t          sb[$];
  logic [DS-1:0] fq[NF][$];
  logic [DS-1:0] buf_r[NF];
  int            glog[$];
  int            n_checks = 0, n_err = 0, cyc = 0, n_pop = 0, n_push = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < NF; i++) begin
      fifo_empty[i]         = (fq[i].size() == 0);
      fifo_data[i*DS +: DS] = buf_r[i];
    end
  endtask

  // One clock: check this cycle's push, log this cycle's pop, then let the
  // upstream FIFO models present the popped word after the edge.
  task automatic step();
    logic [NF-1:0] p;
    #1;
    if (push_out === 1'b1) n_push++;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      check("push_valid", push_out, 1);
      check("push_data", data_out, sb[0].data);
      void'(sb.pop_front());
    end else if (push_out !== 1'b0) begin
      check("push_unexpected", push_out, 0);
    end
    p = pop;
    check("pop_onehot", $onehot0(p), 1);
    for (int i = 0; i < NF; i++) begin
      if (p[i]) begin
        if (fq[i].size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL pop_on_empty: fifo %0d popped while empty, want no pop (cycle %0d)", i, cyc);
        end else begin
          sb.push_back('{data: fq[i][0], due: cyc + 2});
          glog.push_back(i);
          n_pop++;
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NF; i++)
      if (p[i] && fq[i].size() > 0) buf_r[i] = fq[i].pop_front();
    refresh();
    #1;
  endtask

  task automatic run_until_idle(input string name, input int budget);
    int  k = 0;
    logic done = 1'b0;
    while (!done && k < budget) begin
      step();
      k++;
      done = (state == ST_IDLE) && idle_out && (sb.size() == 0);
    end
    check(name, done, 1);
  endtask

  task automatic run_pops(input int target, input int budget);
    int k = 0;
    while (n_pop < target && k < budget) begin
      step();
      k++;
    end
    check("pop_count_reached", n_pop >= target, 1);
  endtask

  vec_t vecs[8];
  int   t3_exp[4];
  int   p0, q0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 1'b1, 4'd6, 4'd2, ST_RESET, 4'd0, 4'd0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 4'd6, 4'd2, ST_INIT,  4'd0, 4'd0, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 4'd6, 4'd2, ST_INIT,  4'd6, 4'd2, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 4'd6, 4'd2, ST_IDLE,  4'd6, 4'd2, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 4'd9, 4'd3, ST_INIT,  4'd6, 4'd2, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 4'd9, 4'd3, ST_IDLE,  4'd9, 4'd3, 1'b1};
    vecs[6] = '{1'b1, 1'b1, 4'd6, 4'd2, ST_INIT,  4'd9, 4'd3, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 4'd6, 4'd2, ST_IDLE,  4'd6, 4'd2, 1'b1};
    t3_exp = '{0, 2, 0, 2};

    fifo_error = '0;
    for (int i = 0; i < NF; i++) buf_r[i] = '0;
    refresh();
    @(posedge clk);
    #1;

    // Reset, INIT threshold programming and INIT/IDLE round trips.
    for (int k = 0; k < 8; k++) begin
      reset_L   = vecs[k].rst_v;
      init      = vecs[k].init_v;
      umb_af_in = vecs[k].af_v;
      umb_ae_in = vecs[k].ae_v;
      step();
      check($sformatf("vec%0d_state", k), state, vecs[k].exp_state);
      check($sformatf("vec%0d_af", k), umb_almost_full, vecs[k].exp_af);
      check($sformatf("vec%0d_ae", k), umb_almost_empty, vecs[k].exp_ae);
      check($sformatf("vec%0d_idle", k), idle_out, vecs[k].exp_idle);
      check($sformatf("vec%0d_pop", k), pop, 0);
      check($sformatf("vec%0d_push", k), push_out, 0);
      check($sformatf("vec%0d_err", k), error_out, 0);
    end

    // Two FIFOs with two words each: alternating grants, pushes A,C,B,D.
    fq[0].push_back(4'hA); fq[0].push_back(4'hB);
    fq[2].push_back(4'hC); fq[2].push_back(4'hD);
    refresh();
    glog.delete();
    run_until_idle("t3_back_to_idle", 30);
    check("t3_num_pops", glog.size(), 4);
    for (int k = 0; k < 4; k++)
      if (glog.size() > k) check($sformatf("t3_grant%0d", k), glog[k], t3_exp[k]);
    check("t3_idle_out", idle_out, 1);

    // Backpressure: stall immediately, drain exactly two in-flight words.
    for (int j = 0; j < 6; j++) begin
      fq[1].push_back(4'(j));
      fq[3].push_back(4'(j + 8));
    end
    refresh();
    run_pops(n_pop + 4, 20);
    down_almost_full = 1'b1;
    p0 = n_pop;
    q0 = n_push;
    repeat (6) step();
    check("t4_no_pop_stalled", n_pop - p0, 0);
    check("t4_inflight_pushes", n_push - q0, 2);
    down_almost_full = 1'b0;
    #1;
    check("t4_resume_pop", |pop, 1);
    run_until_idle("t4_back_to_idle", 40);

    // Upstream error mid-stream: sticky ERROR, no pops, flushed pipeline.
    for (int j = 0; j < 4; j++) fq[0].push_back(4'(j + 3));
    refresh();
    run_pops(n_pop + 2, 20);
    fifo_error = 4'b0010;
    step();
    sb.delete();
    check("t5_state_error", state, ST_ERROR);
    check("t5_error_out", error_out, 1);
    fifo_error = '0;
    for (int k = 0; k < 4; k++) begin
      step();
      check("t5_error_sticky", error_out, 1);
      check("t5_state_sticky", state, ST_ERROR);
      check("t5_pop_blocked", pop, 0);
    end

    reset_L = 1'b0;
    step();
    reset_L = 1'b1;
    for (int i = 0; i < NF; i++) begin
      fq[i].delete();
      buf_r[i] = '0;
    end
    refresh();
    init = 1'b1;
    step();
    step();
    init = 1'b0;
    step();
    check("t5_reinit_idle", state, ST_IDLE);
    check("t5_error_cleared", error_out, 0);

    // All four FIFOs busy: grants rotate 0,1,2,3 and wrap to 0.
    for (int i = 0; i < NF; i++)
      for (int j = 0; j < 2; j++) fq[i].push_back(4'(8 + i*2 + j));
    refresh();
    glog.delete();
    run_until_idle("t6_back_to_idle", 40);
    check("t6_num_pops", glog.size(), 8);
    for (int k = 0; k < 8; k++)
      if (glog.size() > k) check($sformatf("t6_grant%0d", k), glog[k], k % NF);

    // Reset in the middle of traffic discards in-flight words.
    for (int j = 0; j < 3; j++) fq[0].push_back(4'(j + 1));
    refresh();
    run_pops(n_pop + 2, 20);
    reset_L = 1'b0;
    step();
    sb.delete();
    check("t7_state_reset", state, ST_RESET);
    check("t7_no_push_after_reset", push_out, 0);
    check("t7_pop_in_reset", pop, 0);
    reset_L = 1'b1;
    step();
    check("t7_still_no_push", push_out, 0);
    check("t7_state_init", state, ST_INIT);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
